// File: rtl/mm_pkg.sv
// Shared widths and types for the matrix-multiply datapath (array and requantizer).
// C_DATA_WIDTH covers a full product plus accumulator growth.
package mm_pkg;
  localparam int DATA_WIDTH       = 8;
  localparam int ACCUM_DATA_WIDTH = 16;
  localparam int C_DATA_WIDTH     = 2 * DATA_WIDTH + ACCUM_DATA_WIDTH;
  localparam int N                = 4;
  localparam int SHIFT_BITS       = 6;
  localparam int IDX_W            = $clog2(N);

  typedef logic [C_DATA_WIDTH:0]                  acc_ext_t;
  typedef logic [N-1:0][C_DATA_WIDTH-1:0]         c_beat_t;
  typedef logic [N-1:0][DATA_WIDTH-1:0]           q_beat_t;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             last;
    logic             sat;
  } beat_side_t;
endpackage

// File: rtl/c_requantizer_if.sv
// Beat stream into and out of the requantizer: accumulator beats in, requantized beats out.
// master drives the input beat and the output ready; slave is the requantizer.
interface c_requantizer_if;
  import mm_pkg::*;

  logic                  in_valid;
  logic                  in_ready;
  c_beat_t               in_data;
  logic [SHIFT_BITS-1:0] shift_amt;
  logic                  out_valid;
  logic                  out_ready;
  q_beat_t               out_data;
  logic [IDX_W-1:0]      out_index;
  logic                  out_last;
  logic                  out_sat;

  modport master (
    output in_valid, in_data, shift_amt, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, out_sat
  );

  modport slave (
    input  in_valid, in_data, shift_amt, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, out_sat
  );
endinterface

// File: rtl/c_requantizer_lane.sv
// One lane: round (REQUANT_ROUND_EN) and shift on one path, saturate on an independent path.
// Purely combinational, no latency; the two paths sit on either side of a pipeline register.
// No flow control of its own.
module requant_lane
  import mm_pkg::*;
(
  input  logic [C_DATA_WIDTH-1:0] x,
  input  logic [SHIFT_BITS-1:0]   s,
  output acc_ext_t                r,
  input  acc_ext_t                r_in,
  output logic [DATA_WIDTH-1:0]   q,
  output logic                    sat
);
  localparam acc_ext_t QMAX = acc_ext_t'((1 << DATA_WIDTH) - 1);

  acc_ext_t x_ext;

`ifdef REQUANT_ROUND_EN
  acc_ext_t bias;

  // One extra bit of headroom so x + 2^(s-1) can never wrap.
  always_comb begin
    x_ext = {1'b0, x};
    bias  = '0;
    if (s != '0) bias = acc_ext_t'(1) << (s - 1'b1);
    if (s > SHIFT_BITS'(C_DATA_WIDTH)) r = '0;
    else                               r = (x_ext + bias) >> s;
  end
`else
  always_comb begin
    x_ext = {1'b0, x};
    if (s > SHIFT_BITS'(C_DATA_WIDTH)) r = '0;
    else                               r = x_ext >> s;
  end
`endif

  always_comb begin
    sat = (r_in > QMAX);
    q   = sat ? '1 : r_in[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/c_requantizer.sv
// Requantizes streamed C-tile beats (N accumulator lanes) to DATA_WIDTH with per-tile shift; REQUANT_ROUND_EN adds round-half-up.
// Latency: 2 cycles from input handshake to out_valid; 1 beat/cycle sustained.
// Backpressure: two fully stallable stages; in_ready drops only when both hold a beat and out_ready is low.
module c_requantizer
  import mm_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  c_requantizer_if.slave  bus
);
  logic [IDX_W-1:0]          in_cnt;
  logic [SHIFT_BITS-1:0]     shift_q;
  logic [SHIFT_BITS-1:0]     shift_eff;
  logic                      in_fire;

  logic                      s1_vld;
  logic [N-1:0][C_DATA_WIDTH:0] s1_r;
  logic [IDX_W-1:0]          s1_idx;
  logic                      s1_last;
  logic                      s1_load;

  logic                      s2_vld;
  q_beat_t                   s2_dat;
  beat_side_t                s2_side;
  logic                      s2_load;

  logic [N-1:0][C_DATA_WIDTH:0] lane_r;
  q_beat_t                   lane_q;
  logic [N-1:0]              lane_sat;

  always_comb begin
    s2_load       = !s2_vld || bus.out_ready;
    s1_load       = !s1_vld || s2_load;
    bus.in_ready  = !reset && s1_load;
    in_fire       = bus.in_valid && bus.in_ready;
    // Beat 0 uses the live shift; later beats use the value latched on beat 0.
    shift_eff     = (in_cnt == '0) ? bus.shift_amt : shift_q;
    bus.out_valid = s2_vld;
    bus.out_data  = s2_dat;
    bus.out_index = s2_side.index;
    bus.out_last  = s2_side.last;
    bus.out_sat   = s2_side.sat;
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    requant_lane u_lane (
      .x    (bus.in_data[i]),
      .s    (shift_eff),
      .r    (lane_r[i]),
      .r_in (s1_r[i]),
      .q    (lane_q[i]),
      .sat  (lane_sat[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt  <= '0;
      shift_q <= '0;
      s1_vld  <= 1'b0;
      s1_r    <= '0;
      s1_idx  <= '0;
      s1_last <= 1'b0;
      s2_vld  <= 1'b0;
      s2_dat  <= '0;
      s2_side <= '0;
    end else begin
      if (in_fire) begin
        in_cnt <= (in_cnt == IDX_W'(N - 1)) ? '0 : in_cnt + IDX_W'(1);
        if (in_cnt == '0) shift_q <= bus.shift_amt;
      end
      if (s1_load) begin
        s1_vld <= in_fire;
        if (in_fire) begin
          s1_r    <= lane_r;
          s1_idx  <= in_cnt;
          s1_last <= (in_cnt == IDX_W'(N - 1));
        end
      end
      if (s2_load) begin
        s2_vld <= s1_vld;
        if (s1_vld) begin
          s2_dat  <= lane_q;
          s2_side <= '{index: s1_idx, last: s1_last, sat: |lane_sat};
        end
      end
    end
  end
endmodule

// File: doc/c_requantizer.md
# c_requantizer

Downstream stage of the sum-stationary systolic array. It consumes the streamed rows or columns of the C result matrix: N wide accumulator lanes per beat, one beat per valid/ready handshake, N beats per tile. Each lane is requantized to DATA_WIDTH bits by a per-tile right shift, optional round-half-up and unsigned saturation. The result is emitted on a two-stage, fully back-pressurable pipeline with beat index and end-of-tile marking, ready for writeback to the operand buffers of the next layer.

## Interface
- DATA_WIDTH, 8, output element width (matches array operand width)
- N, 4, lanes per beat and beats per tile
- C_DATA_WIDTH, 32, input accumulator lane width (MULTIPLY_DATA_WIDTH + ACCUM_DATA_WIDTH)
- SHIFT_BITS, 6, width of shift amount
- clk  input  1  clock
- reset  input  1  reset, synchronous, active-high
- in_valid  input  1  beat available (driven by array output_valid)
- in_ready  output  1  beat accepted when in_valid && in_ready (drives array output_ready)
- in_data  input  N x C_DATA_WIDTH  unsigned accumulator lanes
- shift_amt  input  SHIFT_BITS  right-shift amount, sampled on the first beat of each tile
- out_valid  output  1  out_data valid
- out_ready  input  1  downstream accepts beat
- out_data  output  N x DATA_WIDTH  requantized lanes
- out_index  output  $clog2(N)  beat index within tile, 0..N-1
- out_last  output  1  high on beat N-1 of a tile
- out_sat  output  1  at least one lane of this beat saturated

## Operation
- Input beat counter counts 0..N-1, incrementing on each input handshake and wrapping to 0 after N-1.
- Shift latch:
  - On a handshake with counter==0, shift_amt is captured and applies to all N beats of the tile.
  - shift_amt is ignored on beats 1..N-1.
- Per-lane arithmetic, carried in C_DATA_WIDTH+1 bits so rounding never overflows:
  - r = (x + (s>0 ? 2^(s-1) : 0)) >> s.
  - s > C_DATA_WIDTH gives r = 0.
  - If r > 2^DATA_WIDTH-1, the lane outputs 2^DATA_WIDTH-1 and marks saturation; otherwise it outputs r[DATA_WIDTH-1:0].
  - out_sat is the OR of the lane saturation flags.
- Stage 1 registers the rounded, shifted values, the beat index and the shift-derived flags. Stage 2 registers the saturated data, index, last and sat.
- Flow control per stage: a stage loads when it is empty or its contents advance the same cycle. in_ready = !s1_valid || (s1 advancing). There are no bubbles, so sustained throughput is 1 beat/cycle.
- Data, index, last and sat hold stable while out_valid && !out_ready.
- Tile orientation (row or column) is transparent to this block; out_index simply numbers beats.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_index=0, out_last=0, out_sat=0.
  - Beat counter=0, shift latch=0, both stage valids=0.
  - in_ready=0 while reset is high and 1 the first cycle after.
- Latency: 2 cycles from input handshake to out_valid, with out_ready held high.
- Backpressure: with out_ready low, both stages fill; in_ready falls once two beats are held.
- Simultaneous input and output handshake when full: both occur, with no loss and no duplication.
- Reset mid-tile: all in-flight beats are discarded, out_valid=0 next cycle, and the next accepted beat is treated as beat 0 with a fresh shift sample.
- Counter wrap: the beat after out_last restarts at index 0 with no idle cycle required.

## Configuration
- REQUANT_ROUND_EN defined: round-half-up, i.e. 2^(s-1) is added before the shift when s>0.
- REQUANT_ROUND_EN undefined: pure truncating shift with no rounding adder. Saturation and all timing are identical.

## Structure
- Shared package mm_pkg holds:
  - C_DATA_WIDTH derivation (2*DATA_WIDTH + ACCUM_DATA_WIDTH).
  - Beat index width ($clog2(N)).
  - A typedef for the per-beat sideband struct {index, last, sat}.
- One combinational sub-module, requant_lane (round, shift, saturate one lane), instantiated N times. All registers and flow control stay in c_requantizer.

## Test plan
1. shift=4, lanes {100,255,4095,8}:
   - With REQUANT_ROUND_EN: out {6,16,255,1}, out_sat=1.
   - Without: out {6,15,255,0}, out_sat=0.
2. Four back-to-back beats, out_ready=1: first out_valid 2 cycles after the first handshake; out_index 0,1,2,3; out_last only on index 3; in_ready stays 1.
3. out_ready low for 5 cycles during beat 1: in_ready drops after 2 beats are buffered; all 4 beats appear once, in order, with values unchanged.
4. shift_amt=4 on beat 0, changed to 0 on beats 1-3: all four beats use shift 4. The next tile, starting with shift=0, gives 300→255 (sat=1) and 200→200.
5. shift=40 with lanes of 2^32-1: all outputs 0, out_sat=0.
6. reset pulsed after beat 2 is accepted: out_valid=0 next cycle; the next tile's first output has out_index=0 and uses its own shift_amt.
